// File: rtl/spike_event_logger_if.sv
// Register bus between the RISC-V core (master) and the spike event logger (slave).
// Strobes are single-cycle: read/write sampled on a rising edge; read data lands one cycle later and holds.
interface spike_event_logger_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
);
   logic                  risc_v_read;
   logic                  risc_v_write;
   logic [ADDR_WIDTH-1:0] risc_v_addr;
   logic [DATA_WIDTH-1:0] risc_v_data_in;
   logic [DATA_WIDTH-1:0] risc_v_data_out;

   modport master (
      output risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
      input  risc_v_data_out
   );

   modport slave (
      input  risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
      output risc_v_data_out
   );
endinterface

// File: rtl/spike_event_logger.sv
// Timestamps rising edges of spike_in, queues them in a FIFO drained over the register bus,
// with refractory filtering, drop accounting and a level interrupt.
module spike_event_logger #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int REFRACTORY = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spike_in,
   spike_event_logger_if.slave  bus,
   output logic                 spike_irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_DATA    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TSTAMP  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_DROPPED = ADDR_WIDTH'(5);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [DATA_WIDTH-1:0] tstamp;
   logic [DATA_WIDTH-1:0] dropped;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [RW-1:0]         refr_cnt;
   logic                  spike_prev;
   logic                  ctrl_en;
   logic                  ctrl_irq_en;
   logic                  overflow;

   logic empty, full, ctrl_wr, clear, pop, spike_edge, accept, push, drop;
   logic unused_data_bits;

   assign unused_data_bits = ^bus.risc_v_data_in[DATA_WIDTH-1:3];

   assign empty      = (count == '0);
   assign full       = (count == (PW + 1)'(FIFO_DEPTH));
   assign ctrl_wr    = bus.risc_v_write && (bus.risc_v_addr == ADDR_CTRL);
   assign clear      = ctrl_wr && bus.risc_v_data_in[2];
   assign pop        = bus.risc_v_read && (bus.risc_v_addr == ADDR_DATA) && !empty;
   assign spike_edge = spike_in && !spike_prev;
   // A clear in the same cycle wins over any new event.
   assign accept     = spike_edge && ctrl_en && (refr_cnt == '0) && !clear;
   assign push       = accept && (!full || pop);
   assign drop       = accept && full && !pop;

   always_comb begin
      rd_val = '0;
      case (bus.risc_v_addr)
         ADDR_STATUS:  rd_val[4:0] = {ctrl_irq_en, ctrl_en, overflow, full, empty};
         ADDR_COUNT:   rd_val      = DATA_WIDTH'(count);
         ADDR_DATA:    rd_val      = empty ? '0 : mem[rd_ptr];
         ADDR_CTRL:    rd_val[1:0] = {ctrl_irq_en, ctrl_en};
         ADDR_TSTAMP:  rd_val      = tstamp;
         ADDR_DROPPED: rd_val      = dropped;
         default:      rd_val      = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tstamp;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         count               <= '0;
         tstamp              <= '0;
         dropped             <= '0;
         refr_cnt            <= '0;
         spike_prev          <= 1'b0;
         ctrl_en             <= 1'b0;
         ctrl_irq_en         <= 1'b0;
         overflow            <= 1'b0;
         spike_irq           <= 1'b0;
         bus.risc_v_data_out <= '0;
      end else begin
         spike_prev <= spike_in;
         spike_irq  <= ctrl_irq_en && !empty;
         if (bus.risc_v_read) bus.risc_v_data_out <= rd_val;
         if (ctrl_wr) begin
            ctrl_en     <= bus.risc_v_data_in[0];
            ctrl_irq_en <= bus.risc_v_data_in[1];
         end
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
            tstamp   <= '0;
            refr_cnt <= '0;
         end else begin
            if (ctrl_en) tstamp <= tstamp + 1'b1;
            if (accept) refr_cnt <= RW'(REFRACTORY);
            else if (refr_cnt != '0) refr_cnt <= refr_cnt - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) begin
               overflow <= 1'b1;
               if (dropped != '1) dropped <= dropped + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_spike_event_logger.sv
// Directed + short random bench for spike_event_logger; a queue-based model is checked every cycle
// alongside hand-computed register reads.
module tb_spike_event_logger;
   localparam int AW    = 6;
   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int REFR  = 4;

   logic clk = 1'b0;
   logic reset;
   logic spike_in;
   logic spike_irq;

   spike_event_logger_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   spike_event_logger #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .REFRACTORY(REFR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .spike_in  (spike_in),
      .bus       (bus),
      .spike_irq (spike_irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: behavioural model of the logger's visible state.
   logic [DW-1:0] exp_q[$];
   logic          m_en, m_irq_en, m_ovf, m_prev, m_irq;
   logic          m_clr, m_acc, m_pop;
   logic [DW-1:0] m_ts, m_drop, m_dout, m_rv;
   logic [AW-1:0] m_a;
   int            cyc, block_until;

   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_en = 0; m_irq_en = 0; m_ovf = 0; m_prev = 0; m_irq = 0;
         m_ts = '0; m_drop = '0; m_dout = '0;
         cyc = 0; block_until = -1;
      end else begin
         m_a = bus.risc_v_addr;
         case (m_a)
            0:       m_rv = {11'b0, m_irq_en, m_en, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
            1:       m_rv = DW'(exp_q.size());
            2:       m_rv = (exp_q.size() != 0) ? exp_q[0] : '0;
            3:       m_rv = {14'b0, m_irq_en, m_en};
            4:       m_rv = m_ts;
            5:       m_rv = m_drop;
            default: m_rv = '0;
         endcase
         if (bus.risc_v_read) m_dout = m_rv;
         m_irq = m_irq_en && (exp_q.size() != 0);
         m_clr = bus.risc_v_write && (m_a == 3) && bus.risc_v_data_in[2];
         m_acc = spike_in && !m_prev && m_en && (cyc > block_until) && !m_clr;
         m_pop = bus.risc_v_read && (m_a == 2) && (exp_q.size() != 0);
         if (m_clr) begin
            exp_q.delete();
            m_ovf = 0; m_drop = '0; m_ts = '0;
            block_until = cyc;
         end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_acc) begin
               block_until = cyc + REFR;
               if (exp_q.size() < DEPTH) exp_q.push_back(m_ts);
               else begin
                  m_ovf = 1;
                  if (m_drop != '1) m_drop++;
               end
            end
            if (m_en) m_ts++;
         end
         if (bus.risc_v_write && (m_a == 3)) begin
            m_en     = bus.risc_v_data_in[0];
            m_irq_en = bus.risc_v_data_in[1];
         end
         m_prev = spike_in;
         cyc++;
      end
      #1;
      check("model_data_out", bus.risc_v_data_out, m_dout);
      check("model_spike_irq", {15'b0, spike_irq}, {15'b0, m_irq});
   end

   // Driver tasks: inputs change on the falling edge, one rising edge consumed per call.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input int a, input int d);
      bus.risc_v_write   = 1'b1;
      bus.risc_v_addr    = AW'(a);
      bus.risc_v_data_in = DW'(d);
      @(negedge clk);
      bus.risc_v_write   = 1'b0;
   endtask

   task automatic bus_read(input string name, input int a, input int exp);
      bus.risc_v_read = 1'b1;
      bus.risc_v_addr = AW'(a);
      @(negedge clk);
      bus.risc_v_read = 1'b0;
      check(name, bus.risc_v_data_out, DW'(exp));
   endtask

   task automatic pulse();
      spike_in = 1'b1;
      @(negedge clk);
      spike_in = 1'b0;
   endtask

   task automatic check_irq(input string name, input logic exp);
      check(name, {15'b0, spike_irq}, {15'b0, exp});
   endtask

   initial begin
      reset = 1'b1;
      spike_in = 1'b0;
      bus.risc_v_read = 1'b0;
      bus.risc_v_write = 1'b0;
      bus.risc_v_addr = '0;
      bus.risc_v_data_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state
      bus_read("rst_status", 0, 16'h0001);
      bus_read("rst_count", 1, 0);
      bus_read("rst_tstamp", 4, 0);
      bus_read("rst_dropped", 5, 0);
      bus_read("rst_ctrl", 3, 0);
      check_irq("rst_irq", 1'b0);

      // Single event stamped 10
      bus_write(3, 3);
      idle(10);
      pulse();
      idle(1);
      check_irq("one_irq_high", 1'b1);
      bus_read("one_count", 1, 1);
      bus_read("one_status", 0, 16'h0018);
      bus_read("one_data", 2, 10);
      idle(1);
      check_irq("one_irq_low", 1'b0);
      bus_read("one_status_empty", 0, 16'h0019);
      bus_read("one_data_empty", 2, 0);

      // Held level counts once
      bus_write(3, 7);
      spike_in = 1'b1;
      idle(20);
      spike_in = 1'b0;
      bus_read("hold_count", 1, 1);
      bus_read("hold_data", 2, 0);
      bus_read("hold_count_after", 1, 0);

      // Edge inside the refractory window is discarded, not dropped
      bus_write(3, 7);
      idle(4);
      pulse();
      pulse();
      bus_read("refr_count", 1, 1);
      bus_read("refr_data", 2, 4);
      bus_read("refr_dropped", 5, 0);

      // Overflow: 20 events into 16 entries
      bus_write(3, 7);
      for (int i = 0; i < 20; i++) begin
         pulse();
         idle(5);
      end
      bus_read("ovf_count", 1, 16);
      bus_read("ovf_status", 0, 16'h001E);
      bus_read("ovf_dropped", 5, 4);

      // Pop and push together while full
      bus.risc_v_read = 1'b1;
      bus.risc_v_addr = AW'(2);
      spike_in = 1'b1;
      @(negedge clk);
      bus.risc_v_read = 1'b0;
      spike_in = 1'b0;
      check("full_pop_data", bus.risc_v_data_out, 0);
      bus_read("full_pop_count", 1, 16);
      bus_read("full_pop_dropped", 5, 4);
      for (int i = 1; i < 16; i++) bus_read("drain_data", 2, 6 * i);
      bus_read("drain_last", 2, 123);
      bus_read("drain_count", 1, 0);
      bus_read("drain_status", 0, 16'h001D);

      // Clear with entries queued and a coincident edge
      for (int i = 0; i < 3; i++) begin
         pulse();
         idle(5);
      end
      spike_in = 1'b1;
      bus_write(3, 5);
      spike_in = 1'b0;
      bus_read("clr_tstamp", 4, 0);
      bus_read("clr_count", 1, 0);
      bus_read("clr_status", 0, 16'h0009);
      bus_read("clr_dropped", 5, 0);
      bus_read("clr_data", 2, 0);
      check_irq("clr_irq", 1'b0);

      // Random traffic, checked by the model only
      bus_write(3, 3);
      for (int i = 0; i < 400; i++) begin
         spike_in = ($urandom_range(0, 3) == 0);
         bus.risc_v_read = ($urandom_range(0, 2) == 0);
         bus.risc_v_addr = AW'($urandom_range(0, 7));
         bus.risc_v_write = ($urandom_range(0, 24) == 0);
         bus.risc_v_data_in = DW'($urandom_range(0, 3) | (($urandom_range(0, 5) == 0) ? 4 : 0));
         if (bus.risc_v_write && bus.risc_v_addr == 3) bus.risc_v_data_in[0] = 1'b1;
         @(negedge clk);
      end
      spike_in = 1'b0;
      bus.risc_v_read = 1'b0;
      bus.risc_v_write = 1'b0;

      // Asynchronous reset mid-operation
      bus_write(3, 7);
      pulse();
      idle(5);
      pulse();
      idle(2);
      bus_read("pre_rst_count", 1, 2);
      check_irq("pre_rst_irq", 1'b1);
      reset = 1'b1;
      #1;
      check("async_rst_dout", bus.risc_v_data_out, 0);
      check_irq("async_rst_irq", 1'b0);
      idle(2);
      reset = 1'b0;
      bus_read("post_rst_status", 0, 16'h0001);
      bus_read("post_rst_count", 1, 0);
      bus_read("post_rst_tstamp", 4, 0);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
